// File: rtl/watchdog_core.sv
// Windowed watchdog: a closed first window (service is an error), an open second window
// (service required), error counting with an optional reset-request fault. Option: WD_PRESCALER_EN.
module watchdog_core (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] FWLEN,
    input  logic [7:0] SWLEN,
    input  logic [7:0] RST_LMT,
    input  logic       WDSRVC,
    input  logic       INIT,
    output logic       WDRST,
    output logic       ERR_PLS,
    output logic [7:0] ERR_CNT,
    output logic [1:0] WDSTATE,
    output logic       WINOPEN
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FIRST  = 2'b01,
        S_SECOND = 2'b10,
        S_FAULT  = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_srvc_q;
    logic [7:0] r_win_cnt;
    logic [7:0] w_win_cnt_nxt;
    logic [7:0] r_err_cnt;
    logic [7:0] w_err_cnt_nxt;
    logic       r_err_pls;
    logic       w_err_evt;
    logic       w_srvc_evt;
    logic       w_tick;
    logic       w_win_entry;
    logic [7:0] w_fw_last;
    logic [7:0] w_sw_last;
    logic [7:0] w_err_inc;

    assign w_srvc_evt = WDSRVC & ~r_srvc_q;
    assign w_fw_last  = (FWLEN == 8'd0) ? 8'd0 : FWLEN - 8'd1;
    assign w_sw_last  = (SWLEN == 8'd0) ? 8'd0 : SWLEN - 8'd1;
    assign w_err_inc  = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;

`ifdef WD_PRESCALER_EN
    logic [7:0] r_presc;

    // A window restart also restarts the prescaler so every window is an exact tick multiple.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_presc <= '0;
        end else if (r_state == S_IDLE || w_win_entry) begin
            r_presc <= '0;
        end else if (r_state != S_FAULT) begin
            r_presc <= r_presc + 8'd1;
        end
    end

    assign w_tick = (r_presc == 8'hFF);
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= S_IDLE;
            r_win_cnt <= '0;
            r_err_cnt <= '0;
            r_err_pls <= 1'b0;
            r_srvc_q  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_win_cnt <= w_win_cnt_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_err_pls <= w_err_evt;
            r_srvc_q  <= WDSRVC;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_win_cnt_nxt = r_win_cnt;
        w_err_evt     = 1'b0;
        w_win_entry   = 1'b0;
        if (!INIT) begin
            w_next        = S_IDLE;
            w_win_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next        = S_FIRST;
                    w_win_cnt_nxt = '0;
                    w_win_entry   = 1'b1;
                end
                S_FIRST: begin
                    if (w_srvc_evt) begin
                        w_err_evt     = 1'b1;
                        w_win_cnt_nxt = '0;
                        w_win_entry   = 1'b1;
                    end else if (w_tick) begin
                        if (r_win_cnt == w_fw_last) begin
                            w_next        = S_SECOND;
                            w_win_cnt_nxt = '0;
                            w_win_entry   = 1'b1;
                        end else begin
                            w_win_cnt_nxt = r_win_cnt + 8'd1;
                        end
                    end
                end
                S_SECOND: begin
                    if (w_srvc_evt) begin
                        w_next        = S_FIRST;
                        w_win_cnt_nxt = '0;
                        w_win_entry   = 1'b1;
                    end else if (w_tick) begin
                        if (r_win_cnt == w_sw_last) begin
                            w_err_evt     = 1'b1;
                            w_next        = S_FIRST;
                            w_win_cnt_nxt = '0;
                            w_win_entry   = 1'b1;
                        end else begin
                            w_win_cnt_nxt = r_win_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    w_next = S_FAULT;
                end
            endcase
        end

        // Fault check uses the post-increment count so FAULT lands on the same edge.
        w_err_cnt_nxt = r_err_cnt;
        if (!INIT || r_state == S_IDLE) begin
            w_err_cnt_nxt = '0;
        end else if (w_err_evt) begin
            w_err_cnt_nxt = w_err_inc;
            if (RST_LMT != 8'd0 && w_err_inc >= RST_LMT) begin
                w_next = S_FAULT;
            end
        end
    end

    always_comb begin
        WDSTATE = r_state;
        WINOPEN = (r_state == S_SECOND);
        WDRST   = (r_state == S_FAULT);
        ERR_PLS = r_err_pls;
        ERR_CNT = r_err_cnt;
    end

endmodule

// File: tb/tb_watchdog_core.sv
// Self-checking bench for watchdog_core: directed scenarios plus random service/enable
// traffic, all compared against a cycle-count reference model of the window rules.
module tb_watchdog_core;

`ifdef WD_PRESCALER_EN
    localparam int P = 256;
    localparam int SAT_ERRS = 20;
`else
    localparam int P = 1;
    localparam int SAT_ERRS = 300;
`endif

    logic       CLK;
    logic       RST;
    logic [7:0] FWLEN;
    logic [7:0] SWLEN;
    logic [7:0] RST_LMT;
    logic       WDSRVC;
    logic       INIT;
    logic       WDRST;
    logic       ERR_PLS;
    logic [7:0] ERR_CNT;
    logic [1:0] WDSTATE;
    logic       WINOPEN;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 IDLE, 1 FIRST, 2 SECOND, 3 FAULT; window time kept in raw cycles.
    int m_state   = 0;
    int m_elapsed = 0;
    int m_err     = 0;
    bit m_pls     = 0;
    bit m_prev    = 0;

    logic [12:0] obs;
    logic [12:0] exp_v;

    watchdog_core dut (
        .CLK     (CLK),
        .RST     (RST),
        .FWLEN   (FWLEN),
        .SWLEN   (SWLEN),
        .RST_LMT (RST_LMT),
        .WDSRVC  (WDSRVC),
        .INIT    (INIT),
        .WDRST   (WDRST),
        .ERR_PLS (ERR_PLS),
        .ERR_CNT (ERR_CNT),
        .WDSTATE (WDSTATE),
        .WINOPEN (WINOPEN)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int win_cycles(input logic [7:0] len);
        return ((len == 8'd0) ? 1 : int'(len)) * P;
    endfunction

    function automatic logic [12:0] m_out();
        logic [1:0] s;
        logic [7:0] e;
        s = 2'(m_state);
        e = 8'(m_err);
        return {s, (m_state == 2), (m_state == 3), m_pls, e};
    endfunction

    task automatic model_reset();
        m_state = 0; m_elapsed = 0; m_err = 0; m_pls = 0; m_prev = 0;
    endtask

    task automatic model_step();
        bit evt;
        bit err;
        evt    = WDSRVC && !m_prev;
        m_prev = WDSRVC;
        err    = 0;
        m_pls  = 0;
        if (!INIT) begin
            m_state = 0; m_elapsed = 0; m_err = 0;
        end else begin
            case (m_state)
                0: begin m_state = 1; m_elapsed = 0; end
                1: begin
                    if (evt) begin
                        err = 1; m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == win_cycles(FWLEN)) begin m_state = 2; m_elapsed = 0; end
                    end
                end
                2: begin
                    if (evt) begin
                        m_state = 1; m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                        if (m_elapsed == win_cycles(SWLEN)) begin
                            err = 1; m_state = 1; m_elapsed = 0;
                        end
                    end
                end
                default: ;
            endcase
            if (err) begin
                if (m_err < 255) m_err++;
                m_pls = 1;
                if (RST_LMT != 0 && m_err >= int'(RST_LMT)) m_state = 3;
            end
        end
    endtask

    task automatic clk_step();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b0; INIT = 1'b1; WDSRVC = 1'b0;
        FWLEN = 8'd4; SWLEN = 8'd4; RST_LMT = 8'd0;
        #2;
        obs = {WDSTATE, WINOPEN, WDRST, ERR_PLS, ERR_CNT};
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL reset_values got=%h exp=%h", obs, 13'h0);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        model_reset();
        clk_step();
        n_checks++;
        if (WDSTATE !== 2'b01) begin
            n_fail++; $display("FAIL reset_release_first_win got=%b exp=01", WDSTATE);
        end
    endtask

    task automatic test_timeout();
        int exp_s;
        INIT = 1'b0; clk_step();
        INIT = 1'b1; FWLEN = 8'd4; SWLEN = 8'd4; RST_LMT = 8'd0;
        for (int k = 1; k <= 8*P + 1; k++) begin
            clk_step();
            exp_s = (k <= 4*P) ? 1 : (k <= 8*P) ? 2 : 1;
            obs = {WDSTATE, WINOPEN, WDRST, ERR_PLS, ERR_CNT};
            exp_v = m_out();
            n_checks++;
            if (obs !== exp_v || int'(WDSTATE) != exp_s) begin
                n_fail++;
                $display("FAIL timeout k=%0d got=%h exp=%h state_exp=%0d", k, obs, exp_v, exp_s);
            end
        end
        n_checks++;
        if (ERR_PLS !== 1'b1 || ERR_CNT !== 8'd1) begin
            n_fail++; $display("FAIL timeout_error got pls=%b cnt=%0d exp pls=1 cnt=1", ERR_PLS, ERR_CNT);
        end
    endtask

    task automatic test_first_service();
        int exp_s;
        INIT = 1'b0; WDSRVC = 1'b0; clk_step();
        INIT = 1'b1;
        clk_step();
        clk_step();
        WDSRVC = 1'b1;
        clk_step();
        n_checks++;
        if (ERR_CNT !== 8'd1 || ERR_PLS !== 1'b1 || WDSTATE !== 2'b01) begin
            n_fail++;
            $display("FAIL first_win_service got cnt=%0d pls=%b st=%b exp cnt=1 pls=1 st=01",
                     ERR_CNT, ERR_PLS, WDSTATE);
        end
        for (int j = 1; j <= 4*P; j++) begin
            clk_step();
            exp_s = (j < 4*P) ? 1 : 2;
            obs = {WDSTATE, WINOPEN, WDRST, ERR_PLS, ERR_CNT};
            exp_v = m_out();
            n_checks++;
            if (obs !== exp_v || int'(WDSTATE) != exp_s) begin
                n_fail++;
                $display("FAIL first_win_restart j=%0d got=%h exp=%h state_exp=%0d", j, obs, exp_v, exp_s);
            end
        end
        WDSRVC = 1'b0;
    endtask

    task automatic wait_second(input string tag);
        int budget;
        budget = 10*P + 10;
        while (m_state != 2 && budget > 0) begin
            clk_step();
            budget--;
        end
        n_checks++;
        if (WDSTATE !== 2'b10 || m_state != 2) begin
            n_fail++; $display("FAIL %s_reach_second got=%b exp=10", tag, WDSTATE);
        end
    endtask

    task automatic test_second_service();
        INIT = 1'b0; WDSRVC = 1'b0; clk_step();
        INIT = 1'b1;
        wait_second("svc_mid");
        clk_step(); clk_step();
        WDSRVC = 1'b1;
        clk_step();
        n_checks++;
        if (WDSTATE !== 2'b01 || ERR_CNT !== 8'd0 || ERR_PLS !== 1'b0) begin
            n_fail++;
            $display("FAIL second_win_service got st=%b cnt=%0d pls=%b exp st=01 cnt=0 pls=0",
                     WDSTATE, ERR_CNT, ERR_PLS);
        end
        WDSRVC = 1'b0;
        wait_second("svc_last");
        repeat (4*P - 1) clk_step();
        n_checks++;
        if (WDSTATE !== 2'b10) begin
            n_fail++; $display("FAIL second_win_before_last got=%b exp=10", WDSTATE);
        end
        WDSRVC = 1'b1;
        clk_step();
        n_checks++;
        if (WDSTATE !== 2'b01 || ERR_CNT !== 8'd0 || ERR_PLS !== 1'b0) begin
            n_fail++;
            $display("FAIL second_win_last_tick got st=%b cnt=%0d pls=%b exp st=01 cnt=0 pls=0",
                     WDSTATE, ERR_CNT, ERR_PLS);
        end
        WDSRVC = 1'b0;
    endtask

    task automatic test_fault();
        int budget;
        INIT = 1'b0; WDSRVC = 1'b0; clk_step();
        INIT = 1'b1; RST_LMT = 8'd3;
        budget = 3*8*P + 10;
        while (m_state != 3 && budget > 0) begin
            clk_step();
            budget--;
            obs = {WDSTATE, WINOPEN, WDRST, ERR_PLS, ERR_CNT};
            exp_v = m_out();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL fault_approach got=%h exp=%h", obs, exp_v);
            end
        end
        n_checks++;
        if (WDRST !== 1'b1 || WDSTATE !== 2'b11 || ERR_CNT !== 8'd3) begin
            n_fail++;
            $display("FAIL fault_entry got rst=%b st=%b cnt=%0d exp rst=1 st=11 cnt=3", WDRST, WDSTATE, ERR_CNT);
        end
        for (int i = 0; i < 6; i++) begin
            WDSRVC = ~WDSRVC;
            clk_step();
            n_checks++;
            if (WDSTATE !== 2'b11 || ERR_CNT !== 8'd3 || ERR_PLS !== 1'b0) begin
                n_fail++;
                $display("FAIL fault_hold i=%0d got st=%b cnt=%0d pls=%b exp st=11 cnt=3 pls=0",
                         i, WDSTATE, ERR_CNT, ERR_PLS);
            end
        end
        INIT = 1'b0; WDSRVC = 1'b0;
        clk_step();
        n_checks++;
        if (WDSTATE !== 2'b00 || ERR_CNT !== 8'd0 || WDRST !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_exit got st=%b cnt=%0d rst=%b exp st=00 cnt=0 rst=0", WDSTATE, ERR_CNT, WDRST);
        end
        RST_LMT = 8'd0;
    endtask

    task automatic test_async_reset();
        INIT = 1'b0; clk_step();
        INIT = 1'b1;
        wait_second("async");
        clk_step();
        #2 RST = 1'b0;
        #1;
        obs = {WDSTATE, WINOPEN, WDRST, ERR_PLS, ERR_CNT};
        n_checks++;
        if (obs !== 13'h0) begin
            n_fail++; $display("FAIL async_reset_values got=%h exp=%h", obs, 13'h0);
        end
        model_reset();
        #1 RST = 1'b1;
        clk_step();
        n_checks++;
        if (WDSTATE !== 2'b01 || ERR_CNT !== 8'd0) begin
            n_fail++; $display("FAIL async_reset_reentry got st=%b cnt=%0d exp st=01 cnt=0", WDSTATE, ERR_CNT);
        end
    endtask

    task automatic test_saturation();
        int budget;
        int edge_no;
        int first_err;
        INIT = 1'b0; WDSRVC = 1'b0; clk_step();
        INIT = 1'b1; FWLEN = 8'd1; SWLEN = 8'd1; RST_LMT = 8'd0;
        budget    = SAT_ERRS * 2 * P + 10;
        edge_no   = 0;
        first_err = -1;
        for (int e = 0; e < SAT_ERRS && budget > 0; ) begin
            clk_step();
            budget--;
            edge_no++;
            if (m_pls) e++;
            if (ERR_PLS === 1'b1 && first_err < 0) first_err = edge_no;
            obs = {WDSTATE, WINOPEN, WDRST, ERR_PLS, ERR_CNT};
            exp_v = m_out();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL saturation edge=%0d got=%h exp=%h", edge_no, obs, exp_v);
            end
        end
        n_checks++;
        if (first_err != 1 + 2*P) begin
            n_fail++; $display("FAIL first_error_edge got=%0d exp=%0d", first_err, 1 + 2*P);
        end
        n_checks++;
        if (ERR_CNT !== 8'(SAT_ERRS > 255 ? 255 : SAT_ERRS) || WDSTATE === 2'b11) begin
            n_fail++;
            $display("FAIL saturation_final got cnt=%0d st=%b exp cnt=%0d no fault",
                     ERR_CNT, WDSTATE, (SAT_ERRS > 255 ? 255 : SAT_ERRS));
        end
    endtask

    task automatic test_random();
        INIT = 1'b0; clk_step();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                INIT    = 1'b0;
                FWLEN   = 8'($urandom_range(0, 6));
                SWLEN   = 8'($urandom_range(0, 6));
                RST_LMT = 8'($urandom_range(0, 5));
            end else begin
                INIT = 1'b1;
            end
            if ($urandom_range(0, 9) < 2) WDSRVC = ~WDSRVC;
            clk_step();
            obs = {WDSTATE, WINOPEN, WDRST, ERR_PLS, ERR_CNT};
            exp_v = m_out();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_v);
            end
        end
        WDSRVC = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_first_service();
        test_second_service();
        test_fault();
        test_async_reset();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/watchdog_core.md
WATCHDOG_CORE -- requirements
Module: watchdog_core

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low; ports are named CLK and RST.
REQ-002 CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 RST  input  1  asynchronous active-low reset.
REQ-004 FWLEN  input  8  first (closed) window length, in ticks.
REQ-005 SWLEN  input  8  second (open) window length, in ticks.
REQ-006 RST_LMT  input  8  error count that triggers a watchdog reset; 0 disables the trigger.
REQ-007 WDSRVC  input  1  service bit, level; each 0->1 transition is one service event.
REQ-008 INIT  input  1  watchdog enable, level.
REQ-009 WDRST  output  1  watchdog reset request; high while in FAULT.
REQ-010 ERR_PLS  output  1  one-cycle pulse per error event.
REQ-011 ERR_CNT  output  8  accumulated error events, saturating.
REQ-012 WDSTATE  output  2  current state: 00 IDLE, 01 FIRST_WIN, 10 SECOND_WIN, 11 FAULT.
REQ-013 WINOPEN  output  1  high only in SECOND_WIN.

Function
REQ-014 Service edge detect: register WDSRVC each cycle; event = WDSRVC high and registered copy low; the register updates in all states.
REQ-015 Tick: one tick per CLK cycle, unless modified by REQ-032.
REQ-016 Window counter: 8 bits, cleared on every window entry, incremented per tick; a length input of 0 is treated as 1.
REQ-017 IDLE: counters held at 0; INIT high -> FIRST_WIN on the next edge.
REQ-018 FIRST_WIN: service event -> error event, counter cleared, stay in FIRST_WIN.
REQ-019 FIRST_WIN: tick with counter == max(FWLEN,1)-1 and no service event -> SECOND_WIN, counter cleared.
REQ-020 SECOND_WIN: service event -> FIRST_WIN, counter cleared, no error.
REQ-021 SECOND_WIN: tick with counter == max(SWLEN,1)-1 and no service event -> error event, FIRST_WIN, counter cleared.
REQ-022 Simultaneous events: a service event in the same cycle as a window's last tick takes priority: error in FIRST_WIN, valid service in SECOND_WIN.
REQ-023 Error event: ERR_PLS high for exactly the following cycle; ERR_CNT increments, saturating at 255.
REQ-024 Fault: on an error event where RST_LMT != 0 and the incremented ERR_CNT >= RST_LMT -> FAULT on the same edge as the increment.
REQ-025 FAULT: WDRST = 1, counters frozen, service events ignored; exit only via INIT low or reset.
REQ-026 INIT low in any non-IDLE state -> IDLE on the next edge; window counter and ERR_CNT cleared; WDRST low; overrides every other transition in that cycle.
REQ-027 Config inputs are sampled live; a length change takes effect at the next counter compare.
REQ-028 All outputs are registered; no combinational path from input to output.

Reset
REQ-029 RST low asynchronously forces IDLE, window counter 0, ERR_CNT 0, WDRST 0, ERR_PLS 0, WINOPEN 0, WDSTATE 00, and edge-detect register 0.
REQ-030 RST asserted mid-window or in FAULT SHALL abort immediately; no error is recorded.
REQ-031 After RST deasserts, with INIT already high, FIRST_WIN SHALL be entered on the first CLK edge.

Configuration
REQ-032 Macro WD_PRESCALER_EN: when defined, an 8-bit prescaler divides CLK so one tick occurs every 256 cycles; the prescaler is cleared on reset, on IDLE, and on every window entry. When the macro is undefined, one tick occurs every cycle and no prescaler logic exists.

Verification
REQ-033 Macro off, FWLEN=4, SWLEN=4, INIT=1, no service -> FIRST_WIN 4 cycles, SECOND_WIN 4 cycles, ERR_PLS pulse, ERR_CNT=1, back in FIRST_WIN.
REQ-034 Service edge at cycle 2 of FIRST_WIN -> ERR_CNT=1, FIRST_WIN restarts with counter 0.
REQ-035 Service edge in SECOND_WIN, including on its last tick -> FIRST_WIN, ERR_CNT unchanged, no ERR_PLS.
REQ-036 RST_LMT=3 with three consecutive SECOND_WIN timeouts -> WDRST=1, WDSTATE=11; INIT low -> IDLE, ERR_CNT=0, WDRST=0.
REQ-037 RST pulsed low mid-SECOND_WIN, not aligned to CLK -> outputs reset immediately; FIRST_WIN re-entered after release.
REQ-038 Macro on, FWLEN=1, SWLEN=1, no service -> first error after 512 cycles; RST_LMT=0 and 300 errors -> ERR_CNT=255, no FAULT.
